// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampled UART receiver feeding a first-word fall-through result FIFO
// Define UART_RX_MAJORITY_EN for 2-of-3 voting on every data, parity and stop sample.
module uart_rx_fifo #(
   parameter int CLK_DIV    = 50,
   parameter int OVERSAMPLE = 8,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_AW    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [DATA_BITS-1:0] m_data,
   output logic                 m_perr,
   output logic [FIFO_AW:0]     fifo_count,
   output logic                 frame_err,
   output logic                 overrun
);
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int OS_W  = $clog2(OVERSAMPLE);
   localparam int BIT_W = $clog2(DATA_BITS);
   localparam int CNT_W = FIFO_AW + 1;
   localparam int DEPTH = 1 << FIFO_AW;
`ifdef UART_RX_MAJORITY_EN
   localparam int SAMPLE_I = OVERSAMPLE / 2 + 1;
`else
   localparam int SAMPLE_I = OVERSAMPLE - 1;
`endif
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0]  HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0]  SAMPLE_AT = OS_W'(SAMPLE_I);
   localparam logic [OS_W-1:0]  ENTRY     = OS_W'((SAMPLE_I + 1) % OVERSAMPLE);
   localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic                 rxd_meta_q, rxd_sync_q;
   logic [DIV_W-1:0]     div_q;
   logic                 tick, sample_now, sample_bit;
   state_t               state_q;
   logic                 armed_q, pen_q, podd_q, par_q, perr_q, push_q;
   logic [OS_W-1:0]      start_cnt_q, sample_cnt_q;
   logic [BIT_W-1:0]     bit_cnt_q;
   logic [DATA_BITS-1:0] shift_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
         div_q      <= '0;
      end else begin
         rxd_meta_q <= rxd;
         rxd_sync_q <= rxd_meta_q;
         div_q      <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      end
   end

   assign tick       = (div_q == DIV_LAST);
   assign sample_now = tick && (sample_cnt_q == SAMPLE_AT);

`ifdef UART_RX_MAJORITY_EN
   // Two earlier votes are held; the live synchronised value is the third.
   logic [1:0] vote_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         vote_q <= '0;
      end else if (tick) begin
         if (sample_cnt_q == SAMPLE_AT - OS_W'(2)) vote_q[0] <= rxd_sync_q;
         if (sample_cnt_q == SAMPLE_AT - OS_W'(1)) vote_q[1] <= rxd_sync_q;
      end
   end
   assign sample_bit = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxd_sync_q) | (vote_q[1] & rxd_sync_q);
`else
   assign sample_bit = rxd_sync_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         armed_q      <= 1'b1;
         start_cnt_q  <= '0;
         sample_cnt_q <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         pen_q        <= 1'b0;
         podd_q       <= 1'b0;
         par_q        <= 1'b0;
         perr_q       <= 1'b0;
         push_q       <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         push_q    <= 1'b0;
         frame_err <= 1'b0;
         if (tick && state_q != IDLE)
            sample_cnt_q <= (sample_cnt_q == OS_LAST) ? '0 : sample_cnt_q + 1'b1;
         case (state_q)
            IDLE: begin
               if (rxd_sync_q) armed_q <= 1'b1;
               if (tick) begin
                  if (armed_q && !rxd_sync_q) begin
                     if (start_cnt_q == HALF_LAST) begin
                        state_q      <= DATA;
                        start_cnt_q  <= '0;
                        sample_cnt_q <= ENTRY;
                        bit_cnt_q    <= '0;
                        par_q        <= 1'b0;
                        perr_q       <= 1'b0;
                        pen_q        <= parity_en;
                        podd_q       <= parity_odd;
                     end else begin
                        start_cnt_q <= start_cnt_q + 1'b1;
                     end
                  end else begin
                     start_cnt_q <= '0;
                  end
               end
            end
            DATA: if (sample_now) begin
               shift_q <= {sample_bit, shift_q[DATA_BITS-1:1]};
               par_q   <= par_q ^ sample_bit;
               if (bit_cnt_q == BITS_LAST) state_q <= pen_q ? PARITY : STOP;
               else                        bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            PARITY: if (sample_now) begin
               perr_q  <= par_q ^ sample_bit ^ podd_q;
               state_q <= STOP;
            end
            STOP: if (sample_now) begin
               if (sample_bit) begin
                  push_q <= 1'b1;
               end else begin
                  frame_err <= 1'b1;
                  armed_q   <= 1'b0;
               end
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   logic [FIFO_AW:0]   wr_ptr_q, rd_ptr_q;
   logic [DATA_BITS:0] mem_q [DEPTH];
   logic [DATA_BITS:0] head;
   logic               pop, full, wr_en;

   assign fifo_count = wr_ptr_q - rd_ptr_q;
   assign m_valid    = (fifo_count != '0);
   assign full       = (fifo_count == FULL_CNT);
   assign pop        = m_valid && m_ready;
   assign wr_en      = push_q && (!full || pop);
   assign head       = mem_q[rd_ptr_q[FIFO_AW-1:0]];
   assign m_data     = m_valid ? head[DATA_BITS-1:0] : '0;
   assign m_perr     = m_valid & head[DATA_BITS];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         overrun  <= 1'b0;
      end else begin
         overrun <= push_q && full && !pop;
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {perr_q, shift_q};
   end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
`timescale 1ns/1ps
module tb_uart_rx_fifo;
   localparam int BIT_CLKS = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxd = 1'b1;
   logic       parity_en = 1'b0;
   logic       parity_odd = 1'b0;
   logic       m_ready = 1'b0;
   logic       m_valid, m_perr, frame_err, overrun;
   logic [7:0] m_data;
   logic [2:0] fifo_count;

   int checks = 0;
   int errors = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int fe0, ov0;
   bit found;

   always #5 clk = ~clk;

   uart_rx_fifo #(.CLK_DIV(4), .OVERSAMPLE(8), .DATA_BITS(8), .FIFO_AW(2)) dut (
      .clk(clk), .rst(rst), .rxd(rxd), .parity_en(parity_en), .parity_odd(parity_odd),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_perr(m_perr),
      .fifo_count(fifo_count), .frame_err(frame_err), .overrun(overrun)
   );

   always @(negedge clk) begin
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (overrun)   ov_cnt <= ov_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic hold_line(input logic level, input int n);
      rxd = level;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] data, input logic with_par, input logic pbit,
                             input logic stop, input int glitch_at);
      logic [10:0] fb;
      int nbits;
      fb = '0;
      fb[8:1] = data;
      if (with_par) begin
         fb[9] = pbit; fb[10] = stop; nbits = 11;
      end else begin
         fb[9] = stop; nbits = 10;
      end
      for (int c = 0; c < nbits * BIT_CLKS; c++) begin
         rxd = fb[c / BIT_CLKS] ^ (glitch_at >= 0 && c >= glitch_at && c < glitch_at + 4);
         @(negedge clk);
      end
   endtask

   task automatic pop_check(input string tag, input logic [7:0] exp_data, input logic exp_perr);
      check_eq({tag, "_valid"}, m_valid, 1);
      check_eq({tag, "_data"}, m_data, exp_data);
      check_eq({tag, "_perr"}, m_perr, exp_perr);
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_eq("rst_valid", m_valid, 0);
      check_eq("rst_data", m_data, 0);
      check_eq("rst_perr", m_perr, 0);
      check_eq("rst_count", fifo_count, 0);
      check_eq("rst_ferr", frame_err, 0);
      check_eq("rst_ovr", overrun, 0);
      rst = 1'b0;
      hold_line(1, 64);

      send_frame(8'hA5, 0, 0, 1, -1);
      hold_line(1, 16);
      check_eq("t1_count", fifo_count, 1);
      pop_check("t1", 8'hA5, 0);
      check_eq("t1_count_after", fifo_count, 0);
      check_eq("t1_valid_after", m_valid, 0);

      parity_en = 1'b1; parity_odd = 1'b0;
      send_frame(8'h03, 1, 1, 1, -1); hold_line(1, 16); pop_check("t2_even_bad", 8'h03, 1);
      send_frame(8'h03, 1, 0, 1, -1); hold_line(1, 16); pop_check("t2_even_ok", 8'h03, 0);
      parity_odd = 1'b1;
      send_frame(8'h03, 1, 1, 1, -1); hold_line(1, 16); pop_check("t2_odd_ok", 8'h03, 0);
      send_frame(8'h03, 1, 0, 1, -1); hold_line(1, 16); pop_check("t2_odd_bad", 8'h03, 1);
      parity_en = 1'b0; parity_odd = 1'b0;

      fe0 = fe_cnt;
      hold_line(0, 8);
      hold_line(1, 320);
      check_eq("t3_count", fifo_count, 0);
      check_eq("t3_ferr", fe_cnt - fe0, 0);
      send_frame(8'h5A, 0, 0, 1, -1); hold_line(1, 16); pop_check("t3", 8'h5A, 0);

      fe0 = fe_cnt;
      send_frame(8'h7E, 0, 0, 0, -1);
      hold_line(0, 30 * BIT_CLKS);
      check_eq("t4_ferr_pulses", fe_cnt - fe0, 1);
      check_eq("t4_count", fifo_count, 0);
      hold_line(1, 64);
      send_frame(8'h11, 0, 0, 1, -1); hold_line(1, 16); pop_check("t4", 8'h11, 0);

      ov0 = ov_cnt;
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 0, 0, 1, -1);
         hold_line(1, 32);
      end
      check_eq("t5_count_full", fifo_count, 4);
      check_eq("t5_overrun", ov_cnt - ov0, 1);
      for (int i = 1; i <= 4; i++) pop_check($sformatf("t5_pop%0d", i), 8'(i), 0);
      check_eq("t5_count_empty", fifo_count, 0);

      for (int i = 1; i <= 4; i++) begin
         send_frame(8'(i), 0, 0, 1, -1);
         hold_line(1, 32);
      end
      check_eq("t5b_count_full", fifo_count, 4);
      ov0 = ov_cnt;
      found = 1'b0;
      fork
         send_frame(8'h05, 0, 0, 1, -1);
         begin
            for (int k = 0; k < 400 && !found; k++) begin
               if (dut.push_q) begin
                  check_eq("t5b_head", m_data, 8'h01);
                  m_ready = 1'b1;
                  @(negedge clk);
                  m_ready = 1'b0;
                  found = 1'b1;
               end else begin
                  @(negedge clk);
               end
            end
         end
      join
      check_eq("t5b_push_seen", found, 1);
      hold_line(1, 32);
      check_eq("t5b_count", fifo_count, 4);
      check_eq("t5b_overrun", ov_cnt - ov0, 0);
      for (int i = 2; i <= 5; i++) pop_check($sformatf("t5b_pop%0d", i), 8'(i), 0);

      send_frame(8'h99, 0, 0, 1, -1);
      hold_line(1, 32);
      check_eq("t6_pre_count", fifo_count, 1);
      fe0 = fe_cnt;
      fork
         send_frame(8'hC3, 0, 0, 1, -1);
         begin
            repeat (240) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check_eq("t6_rst_valid", m_valid, 0);
            check_eq("t6_rst_data", m_data, 0);
            check_eq("t6_rst_perr", m_perr, 0);
            check_eq("t6_rst_count", fifo_count, 0);
            check_eq("t6_rst_ferr", frame_err, 0);
            check_eq("t6_rst_ovr", overrun, 0);
            rst = 1'b0;
         end
      join
      hold_line(1, 64);
      check_eq("t6_count_after", fifo_count, 0);
      check_eq("t6_ferr_after", fe_cnt - fe0, 0);
      send_frame(8'h3C, 0, 0, 1, -1); hold_line(1, 16); pop_check("t6", 8'h3C, 0);

`ifdef UART_RX_MAJORITY_EN
      send_frame(8'h00, 0, 0, 1, 40); hold_line(1, 16); pop_check("maj", 8'h00, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
